// File: rtl/alu_pkg.sv
// Shared types and field positions for the ALU dispatcher.
// Opcodes, FSM states, instruction field offsets and flag bit indices.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_DIV = 3'd3,
        OP_LI   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_e;

    localparam int OP_LSB  = 29;
    localparam int RD_LSB  = 26;
    localparam int RS1_LSB = 23;
    localparam int RS2_LSB = 20;
    localparam int IMM_W   = 20;

    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_dispatch_if.sv
// Instruction handshake between an instruction source and the dispatcher.
interface alu_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one debug port, one sync write port.
// r0 is never written, so it always reads zero.
module alu_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic [AW-1:0]   dbg_idx,
    output logic [XLEN-1:0] dbg_data,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    assign rd1      = mem[ra1];
    assign rd2      = mem[ra2];
    assign dbg_data = mem[dbg_idx];

endmodule

// File: rtl/alu_dispatch.sv
// Decodes instructions, drives the external ALU, holds operands for the op
// latency, captures result and flags, and writes back to the local regfile.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NREGS      = 8,
    parameter int MULDIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_dispatch_if.slave    in_if,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [2:0]       alu_op,
    input  logic [XLEN-1:0]  alu_c,
    input  logic             alu_fz,
    input  logic             alu_fc,
    input  logic             alu_fn,
    input  logic             alu_fv,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [3:0]       flags_q,
    output logic             err_illegal,
    output logic             err_div0,
    input  logic [2:0]       dbg_idx,
    output logic [XLEN-1:0]  dbg_data
);

    localparam logic [3:0] MD_CNT = 4'(MULDIV_LAT - 1);
    localparam logic [3:0] DIV0_FLG = 4'((1 << FLG_N) | (1 << FLG_V));

    state_e          state_q, state_d;
    logic [3:0]      cnt_q;
    logic [2:0]      rd_q;
    logic [XLEN-1:0] res_q;
    logic [3:0]      flg_q;
    logic            div0_q;
    logic            li_q;
    logic            ill_q;

    logic [2:0]      op, rd, rs1, rs2;
    logic [19:0]     imm;
    logic [XLEN-1:0] rv1, rv2;
    logic [3:0]      alu_flg;
    logic            accept, is_alu, is_li, is_ill;

    assign op  = in_if.in_instr[OP_LSB +: 3];
    assign rd  = in_if.in_instr[RD_LSB +: 3];
    assign rs1 = in_if.in_instr[RS1_LSB +: 3];
    assign rs2 = in_if.in_instr[RS2_LSB +: 3];
    assign imm = in_if.in_instr[IMM_W-1:0];

    assign in_if.in_ready = (state_q == S_IDLE);
    assign accept = in_if.in_valid & in_if.in_ready;

    always_comb begin
        alu_flg        = '0;
        alu_flg[FLG_Z] = alu_fz;
        alu_flg[FLG_C] = alu_fc;
        alu_flg[FLG_N] = alu_fn;
        alu_flg[FLG_V] = alu_fv;
    end

    always_comb begin
        is_alu = 1'b0;
        is_li  = 1'b0;
        is_ill = 1'b0;
        unique case (1'b1)
            (op == OP_LI): is_li  = 1'b1;
            (!op[2]):      is_alu = 1'b1;
            default:       is_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_li)  state_d = S_WB;
                if (accept && is_alu) state_d = S_EXEC;
            end
            S_EXEC:  if (cnt_q == 4'd0) state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            flags_q <= '0;
            div0_q  <= 1'b0;
            li_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            ill_q <= accept & is_ill;
            if (state_q == S_IDLE && accept && is_alu) begin
                alu_a  <= rv1;
                alu_b  <= rv2;
                alu_op <= op;
                cnt_q  <= op[1] ? MD_CNT : 4'd0;
                rd_q   <= rd;
                div0_q <= (op == ALU_DIV) && (rv2 == '0);
                li_q   <= 1'b0;
            end
            if (state_q == S_IDLE && accept && is_li) begin
                rd_q   <= rd;
                res_q  <= {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
                div0_q <= 1'b0;
                li_q   <= 1'b1;
            end
            if (state_q == S_EXEC) begin
                if (cnt_q == 4'd0) begin
                    res_q <= div0_q ? '1 : alu_c;
                    flg_q <= div0_q ? DIV0_FLG : alu_flg;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
            if (state_q == S_WB && !li_q) flags_q <= flg_q;
        end
    end

    assign wb_valid    = (state_q == S_WB);
    assign wb_rd       = rd_q;
    assign wb_data     = res_q;
    assign err_div0    = wb_valid & div0_q;
    assign err_illegal = ill_q;

    alu_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (rs1),
        .ra2      (rs2),
        .rd1      (rv1),
        .rd2      (rv2),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data),
        .we       (wb_valid),
        .wa       (rd_q),
        .wd       (res_q)
    );

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural ALU, register/flag model, directed
// scenarios followed by random instruction streams.
module tb_alu_dispatch;
    import alu_pkg::*;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] alu_a, alu_b, alu_c, wb_data, dbg_data;
    logic [2:0]  alu_op, wb_rd, dbg_idx;
    logic        alu_fz, alu_fc, alu_fn, alu_fv;
    logic        wb_valid, err_illegal, err_div0;
    logic [3:0]  flags_q;

    always #5 clk = ~clk;

    alu_dispatch_if ifc ();

    alu_dispatch #(
        .XLEN       (64),
        .NREGS      (8),
        .MULDIV_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (ifc.slave),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .alu_fz      (alu_fz),
        .alu_fc      (alu_fc),
        .alu_fn      (alu_fn),
        .alu_fv      (alu_fv),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flags_q     (flags_q),
        .err_illegal (err_illegal),
        .err_div0    (err_div0),
        .dbg_idx     (dbg_idx),
        .dbg_data    (dbg_data)
    );

    function automatic logic [63:0] ref_res(input logic [2:0] op,
                                            input logic [63:0] a, b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return (b == 64'd0) ? '1 : a / b;
            default: return 64'd0;
        endcase
    endfunction

    // {Z,C,N,V}; C is carry-out for ADD and borrow for SUB
    function automatic logic [3:0] ref_flg(input logic [2:0] op,
                                           input logic [63:0] a, b);
        logic [64:0] s;
        logic [63:0] c;
        logic        cy, v;
        c  = ref_res(op, a, b);
        cy = 1'b0;
        v  = 1'b0;
        if (op == 3'd0) begin
            s  = {1'b0, a} + {1'b0, b};
            cy = s[64];
            v  = (a[63] == b[63]) && (c[63] != a[63]);
        end else if (op == 3'd1) begin
            cy = (a < b);
            v  = (a[63] != b[63]) && (c[63] != a[63]);
        end
        return {c == 64'd0, cy, c[63], v};
    endfunction

    assign alu_c = ref_res(alu_op, alu_a, alu_b);
    assign {alu_fz, alu_fc, alu_fn, alu_fv} = ref_flg(alu_op, alu_a, alu_b);

    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] m_reg [8];
    logic [3:0]  m_flg;
    logic [63:0] m_a, m_b;
    logic [2:0]  m_op;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 64'd0;
        m_flg = 4'd0;
        m_a   = 64'd0;
        m_b   = 64'd0;
        m_op  = 3'd0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_idx = 3'(i);
            #1 chk(tag, dbg_data, m_reg[i]);
        end
    endtask

    task automatic accept(input logic [31:0] ins);
        int w;
        w = 0;
        while (!ifc.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ifc.in_ready) chk("rdy_timeout", {63'd0, ifc.in_ready}, 64'd1);
        ifc.in_valid = 1'b1;
        ifc.in_instr = ins;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_instr = $urandom;
    endtask

    task automatic run(input logic [2:0] op, rd, rs1, rs2,
                       input logic [19:0] imm);
        logic [63:0] a, b, res;
        logic [3:0]  fl;
        bit          li, ill, d0;
        int          lat;
        a   = m_reg[rs1];
        b   = m_reg[rs2];
        li  = (op == 3'd7);
        ill = (op >= 3'd4) && !li;
        d0  = (op == 3'd3) && (b == 64'd0);
        res = 64'd0;
        fl  = m_flg;
        lat = 1;
        if (li) begin
            res = {{44{imm[19]}}, imm};
        end else if (!ill) begin
            res = d0 ? '1 : ref_res(op, a, b);
            fl  = d0 ? 4'b0011 : ref_flg(op, a, b);
            lat = (op >= 3'd2) ? LAT + 1 : 2;
        end
        accept({op, rd, rs1, rs2, imm});
        if (ill) begin
            @(negedge clk);
            chk("ill_err", {63'd0, err_illegal}, 64'd1);
            chk("ill_nowb", {63'd0, wb_valid}, 64'd0);
            chk("ill_rdy", {63'd0, ifc.in_ready}, 64'd1);
            chk("ill_alu_a", alu_a, m_a);
            return;
        end
        if (!li) begin
            m_a  = a;
            m_b  = b;
            m_op = op;
        end
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (n < lat) begin
                chk("early_wb", {63'd0, wb_valid}, 64'd0);
                chk("busy_rdy", {63'd0, ifc.in_ready}, 64'd0);
                chk("hold_a", alu_a, a);
                chk("hold_b", alu_b, b);
                chk("hold_op", {61'd0, alu_op}, {61'd0, op});
            end
        end
        chk("wb_valid", {63'd0, wb_valid}, 64'd1);
        chk("wb_rd", {61'd0, wb_rd}, {61'd0, rd});
        chk("wb_data", wb_data, res);
        chk("err_div0", {63'd0, err_div0}, {63'd0, d0});
        chk("wb_rdy", {63'd0, ifc.in_ready}, 64'd0);
        if (li) chk("li_alu_a", alu_a, m_a);
        if (rd != 3'd0) m_reg[rd] = res;
        m_flg = fl;
        @(negedge clk);
        chk("flags", {60'd0, flags_q}, {60'd0, m_flg});
        chk("post_wb", {63'd0, wb_valid}, 64'd0);
        chk("post_rdy", {63'd0, ifc.in_ready}, 64'd1);
        dbg_idx = rd;
        #1 chk("rf_wr", dbg_data, m_reg[rd]);
    endtask

    initial begin
        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_instr = 32'd0;
        dbg_idx      = 3'd0;
        model_reset();
        #12;
        chk("rst_a", alu_a, 64'd0);
        chk("rst_flags", {60'd0, flags_q}, 64'd0);
        chk("rst_wb", {63'd0, wb_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", {63'd0, ifc.in_ready}, 64'd1);
        chk("rst_op", {61'd0, alu_op}, 64'd0);
        chk("rst_err", {62'd0, err_illegal, err_div0}, 64'd0);

        run(3'd7, 3'd1, 3'd0, 3'd0, 20'd5);
        run(3'd7, 3'd2, 3'd0, 3'd0, 20'd3);
        run(3'd0, 3'd3, 3'd1, 3'd2, 20'd0);
        chk("t1_flags", {60'd0, flags_q}, 64'd0);
        run(3'd1, 3'd4, 3'd2, 3'd1, 20'd0);
        chk("t2_n", {63'd0, flags_q[FLG_N]}, 64'd1);
        run(3'd2, 3'd5, 3'd1, 3'd2, 20'd0);
        run(3'd3, 3'd6, 3'd1, 3'd0, 20'd0);
        chk("t4_flags", {60'd0, flags_q}, 64'd3);
        run(3'd5, 3'd1, 3'd2, 3'd3, 20'd0);
        sweep("t5_rf");
        run(3'd7, 3'd7, 3'd0, 3'd0, 20'h80001);
        run(3'd7, 3'd0, 3'd0, 3'd0, 20'h12345);
        run(3'd0, 3'd3, 3'd3, 3'd3, 20'd0);

        for (int k = 0; k < 60; k++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = 3'd7;
            run(op, 3'($urandom), 3'($urandom), 3'($urandom), 20'($urandom));
        end
        sweep("rand_rf");

        run(3'd7, 3'd1, 3'd0, 3'd0, 20'd9);
        run(3'd7, 3'd2, 3'd0, 3'd0, 20'd7);
        run(3'd1, 3'd4, 3'd2, 3'd1, 20'd0);
        accept({3'd2, 3'd5, 3'd1, 3'd2, 20'd0});
        @(negedge clk);
        @(negedge clk);
        chk("t6_exec_op", {61'd0, alu_op}, 64'd2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_a", alu_a, 64'd0);
        chk("t6_b", alu_b, 64'd0);
        chk("t6_op", {61'd0, alu_op}, 64'd0);
        chk("t6_flags", {60'd0, flags_q}, 64'd0);
        chk("t6_wb", {63'd0, wb_valid}, 64'd0);
        sweep("t6_rf");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("t6_nowb", {63'd0, wb_valid}, 64'd0);
            chk("t6_rdy", {63'd0, ifc.in_ready}, 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
